// File: rtl/dm_pipe_pkg.sv
// dm_pipe_pkg: shared FSM type, lane constants and helpers for the dm_pipe data memory
package dm_pipe_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int DEF_DATA_W = 16;
    localparam int NBYTES     = DEF_DATA_W / 8;
    // be_merge works on the widest supported word; callers widen and truncate around it
    localparam int MAX_W      = 256;
    localparam int MAX_B      = MAX_W / 8;

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] be
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_B; i++) r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    function automatic bit lat_ok(input int lat);
        return lat >= 1 && lat <= 4;
    endfunction

    function automatic bit width_ok(input int w);
        return w > 0 && w % 8 == 0 && w <= MAX_W;
    endfunction

endpackage

// File: rtl/dm_rd_pipe.sv
// dm_rd_pipe: LAT-deep valid/data/err delay line carrying read responses to the output
//   CLK, RST_N            clock, asynchronous active-low reset (flushes all stages)
//   in_valid/data/err     response captured at the acceptance edge
//   out_valid/data/err    response LAT cycles later; data/err are zero unless valid
module dm_rd_pipe
    import dm_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LAT    = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [LAT-1:0]    v;
    logic [LAT-1:0]    e;
    logic [DATA_W-1:0] d [LAT];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v <= '0;
            e <= '0;
            for (int i = 0; i < LAT; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            e[0] <= in_err;
            d[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                d[i] <= d[i-1];
            end
        end
    end

    assign out_valid = v[LAT-1];
    assign out_err   = e[LAT-1];
    assign out_data  = d[LAT-1];

endmodule

// File: rtl/dm_pipe.sv
// dm_pipe: pipelined data memory with valid/ready requests, byte enables, range check and post-reset clear
//   CLK, RST_N   clock, asynchronous active-low reset
//   req_*        request: valid/ready handshake, write flag, word address, byte enables, write data
//   rsp_*        read response: one-cycle valid pulse, data, out-of-range error (data/err zero when idle)
//   wr_drop      one-cycle pulse after an out-of-range write was discarded
//   init_done    high once every word has been cleared after reset
module dm_pipe
    import dm_pipe_pkg::*;
#(
    parameter int DATA_W   = 8 * NBYTES,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wr_drop,
    output logic                init_done
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    if (!lat_ok(READ_LAT)) begin : g_bad_lat
        $error("dm_pipe: READ_LAT must be within 1..4");
    end
    if (!width_ok(DATA_W)) begin : g_bad_w
        $error("dm_pipe: DATA_W must be a positive multiple of 8");
    end

    state_t            st, st_nxt;
    logic [CW-1:0]     clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              acc, in_range, rd_acc, wr_ok;
    logic [CW-1:0]     idx;
    logic [DATA_W-1:0] rd_word, merged, pipe_data;

    assign acc      = req_valid && req_ready;
    // full-width compare so high address bits can never alias into the array
    assign in_range = req_addr < DEPTH_A;
    assign idx      = req_addr[CW-1:0];
    assign rd_word  = mem[idx];
    assign merged   = DATA_W'(be_merge(MAX_W'(rd_word), MAX_W'(req_wdata), MAX_B'(req_be)));
    assign rd_acc   = acc && !req_write;
    assign wr_ok    = acc && req_write && in_range;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st      <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            st      <= st_nxt;
            clr_cnt <= (st == ST_INIT) ? clr_cnt + CW'(1) : clr_cnt;
        end
    end

    always_comb begin
        st_nxt = (st == ST_INIT && clr_cnt == CW'(DEPTH - 1)) ? ST_RUN : st;
    end

    always_comb begin
        req_ready = st == ST_RUN;
        init_done = st == ST_RUN;
    end

    // array has no reset; INIT overwrites every word before requests are accepted
    always_ff @(posedge CLK) begin
        if (st == ST_INIT) mem[clr_cnt] <= '0;
        else if (wr_ok) mem[idx] <= merged;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) wr_drop <= 1'b0;
        else wr_drop <= acc && req_write && !in_range;
    end

    // zero data enters the pipe for idle and out-of-range slots, keeping idle outputs at 0
    assign pipe_data = (rd_acc && in_range) ? rd_word : '0;

    dm_rd_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_rd_pipe (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (rd_acc),
        .in_data   (pipe_data),
        .in_err    (rd_acc && !in_range),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: tb/tb_dm_pipe.sv
// tb_dm_pipe: scoreboard bench for dm_pipe with DEPTH=8, DATA_W=16, READ_LAT=3
module tb_dm_pipe;

    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic        CLK, RST_N;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_be;
    logic        rsp_valid, rsp_err, wr_drop, init_done;

    typedef struct {
        int          due;
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    int          dq[$];
    logic [15:0] model [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    dm_pipe #(
        .DATA_W   (16),
        .DEPTH    (DEPTH),
        .ADDR_W   (16),
        .READ_LAT (LAT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wr_drop   (wr_drop),
        .init_done (init_done)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        logic ev, ed;
        exp_t e;
        ev = q.size() > 0 && q[0].due == cyc;
        ed = dq.size() > 0 && dq[0] == cyc;
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            e = q.pop_front();
            chk("rsp_data", 32'({rsp_err, rsp_rdata}), 32'({e.err, e.data}));
        end else chk("rsp_idle", 32'({rsp_err, rsp_rdata}), 32'h0);
        chk("wr_drop", 32'(wr_drop), 32'(ed));
        if (ed) void'(dq.pop_front());
    end

    task automatic issue(input logic v, input logic w, input logic [15:0] a,
                         input logic [1:0] be, input logic [15:0] d);
        exp_t e;
        @(posedge CLK);
        #1;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        if (v && w) begin
            if (a < DEPTH) begin
                for (int i = 0; i < 2; i++) if (be[i]) model[a[2:0]][8*i +: 8] = d[8*i +: 8];
            end else dq.push_back(cyc + 1);
        end else if (v) begin
            e.due  = cyc + LAT;
            e.err  = a >= DEPTH;
            e.data = (a < DEPTH) ? model[a[2:0]] : 16'h0;
            q.push_back(e);
        end
    endtask

    task automatic rd(input logic [15:0] a);
        issue(1'b1, 1'b0, a, 2'b00, 16'h0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        issue(1'b1, 1'b1, a, be, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    endtask

    // release reset while hammering a write at addr 2 that INIT must ignore
    task automatic release_and_init;
        int n = 0;
        @(negedge CLK);
        RST_N     = 1;
        req_valid = 1;
        req_write = 1;
        req_addr  = 16'd2;
        req_be    = 2'b11;
        req_wdata = 16'hFFFF;
        do begin
            @(posedge CLK);
            #1;
            n++;
            chk("init_ready_lo", 32'(req_ready && n < DEPTH), 32'h0);
        end while (!req_ready && n < 50);
        req_valid = 0;
        chk("init_len", 32'(n), 32'(DEPTH));
        chk("init_done", 32'(init_done), 32'h1);
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0;
    endtask

    initial begin
        RST_N = 0;
        req_valid = 0;
        req_write = 0;
        req_addr  = 0;
        req_be    = 0;
        req_wdata = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_outs", 32'({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_drop, init_done}), 32'h0);
        release_and_init();

        for (int i = 0; i < DEPTH; i++) rd(16'(i));
        chk("addr2_ignored", 32'(model[2]), 32'h0);

        wr(16'd3, 2'b11, 16'hBEEF);
        wr(16'd3, 2'b01, 16'h1234);
        rd(16'd3);
        wr(16'd4, 2'b00, 16'h5555);
        rd(16'd4);

        wr(16'd0, 2'b11, 16'h1111);
        wr(16'd1, 2'b11, 16'h2222);
        wr(16'd2, 2'b11, 16'h3333);
        rd(16'd0);
        rd(16'd1);
        wr(16'd1, 2'b11, 16'hAAAA);
        rd(16'd2);
        rd(16'd1);
        rd(16'd1);
        wr(16'd1, 2'b10, 16'h5BCC);
        rd(16'd1);

        rd(16'd8);
        rd(16'hFFFF);
        wr(16'h0108, 2'b11, 16'hDEAD);
        wr(16'h0008, 2'b11, 16'hDEAD);
        rd(16'd0);
        idle(LAT + 1);

        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 11)),
                  2'($urandom_range(0, 3)), 16'($urandom));
        idle(LAT + 1);

        wr(16'd5, 2'b11, 16'hC0DE);
        rd(16'd3);
        rd(16'd5);
        @(posedge CLK);
        #1;
        RST_N     = 0;
        req_valid = 0;
        q.delete();
        dq.delete();
        #1;
        chk("rst_async", 32'({req_ready, rsp_valid, rsp_err, rsp_rdata, wr_drop, init_done}), 32'h0);
        repeat (LAT + 2) @(posedge CLK);
        release_and_init();
        rd(16'd5);
        rd(16'd3);
        rd(16'd2);
        idle(LAT + 2);
        chk("sb_drain", 32'(q.size() + dq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
